flex_down_counter: RTL and testbench

Loadable, parameterised down-counter and interval timer. It is the count-down companion to the team's up-counting flex counter. The block captures a reload value on start, then decrements on each enabled cycle. At terminal count it either stops (one-shot) or reloads and continues (auto-reload). It sits beside the flex shift registers as a bit/word-period timer for serial transmit and receive control.

---
 rtl/flex_down_counter.sv | 99 +++++++++
 tb/tb_flex_down_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/flex_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : flex_down_counter
// Brief    : Loadable down-counter / interval timer with one-shot and
//            auto-reload modes; registered count, busy and done outputs.
// Revision : 1.0 - initial release
// ============================================================================
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    input  logic [NUM_CNT_BITS-1:0] reload_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    done
);

    localparam logic [NUM_CNT_BITS-1:0] c_zero = '0;
    localparam logic [NUM_CNT_BITS-1:0] c_one  = NUM_CNT_BITS'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CNT_BITS-1:0] w_count_nxt;
    logic [NUM_CNT_BITS-1:0] r_reload;
    logic [NUM_CNT_BITS-1:0] w_reload_nxt;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_done_nxt;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_count  <= c_zero;
            r_reload <= c_zero;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_busy   <= (w_state_nxt == S_RUN);
            r_done   <= w_done_nxt;
        end
    end

    // Priority: clear, then start, then an enabled decrement while running.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;

        if (clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = c_zero;
        end else if (start) begin
            w_reload_nxt = reload_val;
            if (reload_val != c_zero) begin
                w_state_nxt = S_RUN;
                w_count_nxt = reload_val;
            end else begin
                // A zero period expires immediately.
                w_state_nxt = S_IDLE;
                w_count_nxt = c_zero;
                w_done_nxt  = 1'b1;
            end
        end else if ((r_state == S_RUN) && count_enable) begin
            if (r_count > c_one) begin
                w_count_nxt = r_count - c_one;
            end else begin
                // Terminal event: the count skips 0 in periodic mode.
                w_done_nxt = 1'b1;
                if (auto_reload) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt = c_zero;
                    w_state_nxt = S_IDLE;
                end
            end
        end
    end

    assign count_out = r_count;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_flex_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flex_down_counter
// Brief    : Self-checking bench for flex_down_counter (scoreboard queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flex_down_counter;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] cnt;
        logic         bsy;
        logic         dn;
    } exp_t;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         start;
    logic         count_enable;
    logic         auto_reload;
    logic [N-1:0] reload_val;
    logic [N-1:0] count_out;
    logic         busy;
    logic         done;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    flex_down_counter #(.NUM_CNT_BITS(N)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .start        (start),
        .count_enable (count_enable),
        .auto_reload  (auto_reload),
        .reload_val   (reload_val),
        .count_out    (count_out),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish (got running, expected finished)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // pop and compare once the edge has been taken.
    task automatic step(input logic rn, input logic clr, input logic st,
                        input logic ce, input logic ar, input logic [N-1:0] rv,
                        input logic [N-1:0] e_cnt, input logic e_bsy,
                        input logic e_dn, input string tag);
        exp_t e;
        n_rst        = rn;
        clear        = clr;
        start        = st;
        count_enable = ce;
        auto_reload  = ar;
        reload_val   = rv;
        sb_q.push_back('{cnt: e_cnt, bsy: e_bsy, dn: e_dn});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".count"}, 32'(count_out), 32'(e.cnt));
        chk({tag, ".busy"},  32'(busy),      32'(e.bsy));
        chk({tag, ".done"},  32'(done),      32'(e.dn));
    endtask

    initial begin
        int k;
        logic ce;
        logic [N-1:0] ec;
        n_vec = 0;
        n_err = 0;
        n_rst = 1'b0; clear = 1'b0; start = 1'b0; count_enable = 1'b0;
        auto_reload = 1'b0; reload_val = '0;
        #2;

        // 1: reset dominates start and count_enable
        step(0, 0, 1, 1, 0, 4'd9, 4'd0, 0, 0, "rst0");
        step(0, 0, 1, 1, 0, 4'd9, 4'd0, 0, 0, "rst1");
        step(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "idle0");
        step(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "idle1");

        // 2: one-shot from 5
        step(1, 0, 1, 0, 0, 4'd5, 4'd5, 1, 0, "os_start");
        for (int i = 4; i >= 1; i--)
            step(1, 0, 0, 1, 0, 4'd0, 4'(i), 1, 0, "os_dec");
        step(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, "os_term");
        step(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, "os_hold0");
        step(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, "os_hold1");

        // 3: auto-reload period 3
        step(1, 0, 1, 0, 1, 4'd3, 4'd3, 1, 0, "ar_start");
        for (int i = 1; i <= 9; i++)
            step(1, 0, 0, 1, 1, 4'd0, 4'(3 - (i % 3)), 1, (i % 3) == 0, "ar_run");
        step(1, 1, 0, 1, 1, 4'd0, 4'd0, 0, 0, "ar_clear");

        // 4: gated enable pattern
        step(1, 0, 1, 0, 0, 4'd4, 4'd4, 1, 0, "pat_start");
        step(1, 0, 0, 1, 0, 4'd0, 4'd3, 1, 0, "pat1");
        step(1, 0, 0, 0, 0, 4'd0, 4'd3, 1, 0, "pat2");
        step(1, 0, 0, 0, 0, 4'd0, 4'd3, 1, 0, "pat3");
        step(1, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, "pat4");
        step(1, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, "pat5");
        step(1, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, "pat6");
        step(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, "pat7");

        // 5a: clear mid-run
        step(1, 0, 1, 0, 0, 4'd6, 4'd6, 1, 0, "clr_start");
        for (int i = 5; i >= 2; i--)
            step(1, 0, 0, 1, 0, 4'd0, 4'(i), 1, 0, "clr_dec");
        step(1, 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, "clr_at2");
        // 5b: clear wins over the terminal event
        step(1, 0, 1, 0, 0, 4'd2, 4'd2, 1, 0, "clrt_start");
        step(1, 0, 0, 1, 0, 4'd0, 4'd1, 1, 0, "clrt_dec");
        step(1, 1, 0, 1, 1, 4'd0, 4'd0, 0, 0, "clrt_at1");
        step(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, "clrt_after");

        // 6a: zero reload expires immediately
        step(1, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, "zero_start");
        step(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, "zero_after");

        // 6b: restart mid-run at full scale, start+enable does not decrement
        step(1, 0, 1, 0, 1, 4'd10, 4'd10, 1, 0, "fs_pre");
        for (int i = 9; i >= 7; i--)
            step(1, 0, 0, 1, 1, 4'd0, 4'(i), 1, 0, "fs_pre_dec");
        step(1, 0, 1, 1, 1, 4'd15, 4'd15, 1, 0, "fs_restart");
        k = 0;
        for (int i = 0; i < 40; i++) begin
            ce = (i % 4) != 3;
            if (ce) k++;
            ec = 4'(15 - (k % 15));
            step(1, 0, 0, ce, 1, 4'd0, ec, 1, ce && ((k % 15) == 0), "fs_run");
        end
        step(1, 1, 0, 0, 1, 4'd0, 4'd0, 0, 0, "fs_clear");

        // 6c: start+enable from idle; auto_reload only matters at terminal
        step(1, 0, 1, 1, 0, 4'd7, 4'd7, 1, 0, "se_start");
        for (int i = 6; i >= 1; i--)
            step(1, 0, 0, 1, 1, 4'd0, 4'(i), 1, 0, "se_dec");
        step(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, "se_term");

        // Reset mid-run
        step(1, 0, 1, 0, 0, 4'd5, 4'd5, 1, 0, "mr_start");
        step(0, 0, 1, 1, 1, 4'd9, 4'd0, 0, 0, "mr_rst");
        step(1, 0, 0, 1, 1, 4'd0, 4'd0, 0, 0, "mr_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
